ethernet_inet_checksum_engine: RTL and testbench

Parametrised RFC 1071 ones-complement checksum engine for the 10G receive path.
- Passively taps an AXI-Stream receive bus of configurable width.
- Sums 16-bit network-order words from a runtime byte offset to end of frame, honouring tkeep.
- Adds an optional seed (e.g. a pseudo-header partial sum) and emits a folded, inverted checksum plus a verify flag.
- Replaces the fixed 64-bit ICMP-only counter and serves ICMP, IPv4 header, UDP and TCP checking.

---
 rtl/eth_csum_pkg.sv | 19 +
 rtl/ethernet_csum_fold.sv | 57 +++++
 rtl/ethernet_inet_checksum_engine.sv | 80 ++++++++
 tb/tb_ethernet_inet_checksum_engine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_csum_pkg.sv
// eth_csum_pkg: shared state type and ones-complement helpers for the checksum engine
package eth_csum_pkg;
  localparam int CSUM_W = 16;
  typedef enum logic {IDLE, ACCUM} state_t;
  // Add two values of the given width with end-around carry; operands must fit in width bits.
  function automatic logic [63:0] ones_add(input logic [63:0] a, input logic [63:0] b, input int width);
    logic [64:0] s;
    logic [64:0] c;
    logic [63:0] m;
    m = (width >= 64) ? '1 : (64'd1 << width) - 64'd1;
    s = {1'b0, a} + {1'b0, b};
    c = s >> width;
    return 64'((s & {1'b0, m}) + c);
  endfunction
  // One fold step: low 16 bits plus everything above them.
  function automatic logic [63:0] fold16(input logic [63:0] acc);
    return {48'd0, acc[CSUM_W-1:0]} + (acc >> CSUM_W);
  endfunction
endpackage

// File: rtl/ethernet_csum_fold.sv
// ethernet_csum_fold: capture, two-stage fold and invert of a finished frame sum
module ethernet_csum_fold
  import eth_csum_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_vld,
  input  logic             i_en,
  input  logic             i_err,
  input  logic [ACC_W-1:0] i_acc,
  output logic [15:0]      o_csum,
  output logic             o_csum_valid,
  output logic             o_csum_ok,
  output logic             o_start_err
);
  logic [ACC_W-1:0] acc_q, s1_q, s1_d;
  logic [15:0] s2_q, s2_d, csum_q;
  logic [1:0] sb0_q, sb1_q, sb2_q;
  logic valid_q, ok_q, err_q;
  // Fold arithmetic between pipeline registers.
  always_comb begin
    s1_d = ACC_W'(fold16(64'(acc_q)));
    s2_d = 16'(fold16(64'(s1_q)));
  end
  // Sideband {result strobe, start error strobe} travels alongside the data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      sb0_q <= '0;
      sb1_q <= '0;
      sb2_q <= '0;
      csum_q <= '0;
      valid_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc_q <= i_acc;
      sb0_q <= {i_vld & i_en & ~i_err, i_vld & i_err};
      s1_q <= s1_d;
      sb1_q <= sb0_q;
      s2_q <= s2_d;
      sb2_q <= sb1_q;
      valid_q <= sb2_q[1];
      err_q <= sb2_q[0];
      csum_q <= sb2_q[1] ? ~s2_q : csum_q;
      ok_q <= sb2_q[1] ? (s2_q == 16'hFFFF) : ok_q;
    end
  end
  assign o_csum = csum_q;
  assign o_csum_valid = valid_q;
  assign o_csum_ok = ok_q;
  assign o_start_err = err_q;
endmodule

// File: rtl/ethernet_inet_checksum_engine.sv
// ethernet_inet_checksum_engine: RFC 1071 checksum tap on an AXI-Stream receive bus
module ethernet_inet_checksum_engine
  import eth_csum_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ACC_W  = 32,
  parameter int OFS_W  = 14
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx_axis_tvalid,
  input  logic [DATA_W-1:0]     i_rx_axis_tdata,
  input  logic [DATA_W/8-1:0]   i_rx_axis_tkeep,
  input  logic                  i_rx_axis_tlast,
  input  logic [OFS_W-1:0]      i_csum_start,
  input  logic [ACC_W-1:0]      i_seed,
  input  logic                  i_seed_valid,
  input  logic                  i_frame_en,
  output logic [15:0]           o_csum,
  output logic                  o_csum_valid,
  output logic                  o_csum_ok,
  output logic                  o_start_err
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int NW = DATA_W / 16;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, seed_q, seed_d, cur_seed, bsum, nsum, total;
  logic [31:0] pos_q, pos_d, cur_pos;
  logic [OFS_W-1:0] start_q, start_d, cur_start;
  logic [KEEP_W-1:0] lane_en;
  logic first;
  // Per-beat byte selection, word summing and next-state; the first beat of a frame ignores held state.
  always_comb begin
    first = state_q == IDLE;
    cur_start = first ? i_csum_start : start_q;
    cur_pos = first ? '0 : pos_q;
    cur_seed = i_seed_valid ? i_seed : (first ? '0 : seed_q);
    lane_en = '0;
    for (int k = 0; k < KEEP_W; k++) lane_en[k] = i_rx_axis_tkeep[k] && (cur_pos + 32'(k) >= 32'(cur_start));
    bsum = '0;
    for (int j = 0; j < NW; j++)
      bsum = ACC_W'(ones_add(64'(bsum), {48'd0, lane_en[2*j] ? i_rx_axis_tdata[16*j +: 8] : 8'h00,
                                         lane_en[2*j+1] ? i_rx_axis_tdata[16*j+8 +: 8] : 8'h00}, ACC_W));
    nsum = ACC_W'(ones_add(first ? 64'd0 : 64'(acc_q), 64'(bsum), ACC_W));
    total = ACC_W'(ones_add(64'(nsum), 64'(cur_seed), ACC_W));
    state_d = i_rx_axis_tvalid ? (i_rx_axis_tlast ? IDLE : ACCUM) : state_q;
    acc_d = i_rx_axis_tvalid ? nsum : acc_q;
    pos_d = i_rx_axis_tvalid ? cur_pos + 32'(KEEP_W) : pos_q;
    start_d = i_rx_axis_tvalid ? cur_start : start_q;
    seed_d = i_rx_axis_tvalid ? cur_seed : seed_q;
  end
  // Frame accumulator state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      pos_q <= '0;
      start_q <= '0;
      seed_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      pos_q <= pos_d;
      start_q <= start_d;
      seed_q <= seed_d;
    end
  end
  ethernet_csum_fold #(.ACC_W(ACC_W)) u_fold (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_vld        (i_rx_axis_tvalid & i_rx_axis_tlast),
    .i_en         (i_frame_en),
    .i_err        (cur_start[0]),
    .i_acc        (total),
    .o_csum       (o_csum),
    .o_csum_valid (o_csum_valid),
    .o_csum_ok    (o_csum_ok),
    .o_start_err  (o_start_err)
  );
endmodule

// File: tb/tb_ethernet_inet_checksum_engine.sv
// tb_ethernet_inet_checksum_engine: randomized frames checked against a software RFC 1071 model
module tb_ethernet_inet_checksum_engine;
  localparam int DATA_W = 64;
  localparam int KW = DATA_W / 8;
  localparam int ACC_W = 32;
  localparam int OFS_W = 14;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tvalid = 1'b0;
  logic [DATA_W-1:0] tdata = '0;
  logic [KW-1:0] tkeep = '0;
  logic tlast = 1'b0;
  logic [OFS_W-1:0] cstart = '0;
  logic [ACC_W-1:0] seed = '0;
  logic seed_v = 1'b0;
  logic fen = 1'b0;
  logic [15:0] o_csum;
  logic o_csum_valid, o_csum_ok, o_start_err;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int obs_cyc[$];
  logic [15:0] obs_cs[$];
  logic obs_ok[$];
  int err_cyc[$];

  ethernet_inet_checksum_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OFS_W(OFS_W)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_rx_axis_tvalid (tvalid),
    .i_rx_axis_tdata  (tdata),
    .i_rx_axis_tkeep  (tkeep),
    .i_rx_axis_tlast  (tlast),
    .i_csum_start     (cstart),
    .i_seed           (seed),
    .i_seed_valid     (seed_v),
    .i_frame_en       (fen),
    .o_csum           (o_csum),
    .o_csum_valid     (o_csum_valid),
    .o_csum_ok        (o_csum_ok),
    .o_start_err      (o_start_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o_csum_valid) begin
      obs_cyc.push_back(cyc);
      obs_cs.push_back(o_csum);
      obs_ok.push_back(o_csum_ok);
    end
    if (o_start_err) err_cyc.push_back(cyc);
  end

  // Reference: sum 16-bit big-endian words from start, zero-pad tail, add seed, fold fully, invert.
  function automatic logic [16:0] model(input bq_t b, input int start, input logic [31:0] sd);
    logic [63:0] s;
    s = 64'(sd);
    for (int i = start; i < b.size(); i += 2) s += {b[i], (i + 1 < b.size()) ? b[i+1] : 8'h00};
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
    return {s[15:0] == 16'hFFFF, ~s[15:0]};
  endfunction

  function automatic bq_t rnd_frame(input int len);
    bq_t f;
    for (int i = 0; i < len; i++) f.push_back(8'($urandom));
    return f;
  endfunction

  function automatic bq_t mk_ip();
    logic [7:0] hdr [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                             8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
    bq_t f;
    f = rnd_frame(14);
    for (int i = 0; i < 20; i++) f.push_back(hdr[i]);
    return f;
  endfunction

  task automatic clear_obs();
    obs_cyc.delete();
    obs_cs.delete();
    obs_ok.delete();
    err_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      tvalid = 1'b0;
      tdata = {$urandom, $urandom};
      tkeep = KW'($urandom);
      tlast = 1'($urandom);
      cstart = OFS_W'($urandom);
      seed = $urandom;
      seed_v = 1'($urandom);
      fen = 1'($urandom);
    end
  endtask

  // Drive one frame; only the last masked seed beat carries seed_val, earlier masked beats carry junk.
  task automatic send(input bq_t b, input int start, input logic [31:0] seed_val, input logic [15:0] smask,
                      input logic en, input bit gaps, output int tl, output logic [31:0] eff_seed);
    int nb, n, lastseed;
    nb = (b.size() + KW - 1) / KW;
    lastseed = -1;
    for (int i = 0; i < nb && i < 16; i++) if (smask[i]) lastseed = i;
    eff_seed = (lastseed >= 0) ? seed_val : 32'd0;
    tl = 0;
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      @(posedge clk); #1;
      n = b.size() - i * KW;
      if (n > KW) n = KW;
      tvalid = 1'b1;
      for (int k = 0; k < KW; k++) begin
        tkeep[k] = k < n;
        tdata[8*k +: 8] = (k < n) ? b[i*KW+k] : 8'($urandom);
      end
      tlast = i == nb - 1;
      cstart = (i == 0) ? OFS_W'(start) : OFS_W'($urandom);
      seed_v = (i < 16) && smask[i];
      seed = (i == lastseed) ? seed_val : $urandom;
      fen = (i == nb - 1) ? en : 1'($urandom);
      if (i == nb - 1) tl = cyc + 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    checks++; if (o_csum !== 16'h0) begin failures++; $display("FAIL reset_csum: got %h expected 0000", o_csum); end
    checks++; if (o_csum_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_csum_valid); end
    checks++; if (o_csum_ok !== 1'b0) begin failures++; $display("FAIL reset_ok: got %b expected 0", o_csum_ok); end
    checks++; if (o_start_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", o_start_err); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_vectors();
    bq_t f;
    int tl;
    logic [31:0] es;
    logic [16:0] exp;
    logic [15:0] want [4] = '{16'hB861, 16'h0000, 16'hB860, 16'hB861};
    logic want_ok [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 4; t++) begin
      clear_obs();
      f = mk_ip();
      if (t == 1) begin f[24] = 8'hB8; f[25] = 8'h61; end
      send(f, 14, 32'h0001_0000, (t == 2) ? 16'h1 : 16'h0, 1'b1, 1'b0, tl, es);
      idle(8);
      checks++; if (obs_cs.size() !== 1) begin failures++; $display("FAIL vec%0d_count: got %0d expected 1", t, obs_cs.size()); end
      else begin
        checks++; if (obs_cs[0] !== want[t]) begin failures++; $display("FAIL vec%0d_csum: got %h expected %h", t, obs_cs[0], want[t]); end
        checks++; if (obs_ok[0] !== want_ok[t]) begin failures++; $display("FAIL vec%0d_ok: got %b expected %b", t, obs_ok[0], want_ok[t]); end
        checks++; if (obs_cyc[0] !== tl + 3) begin failures++; $display("FAIL vec%0d_latency: got cycle %0d expected %0d", t, obs_cyc[0], tl + 3); end
      end
    end
    clear_obs();
    f = rnd_frame(34);
    f.push_back(8'hAB);
    send(f, 14, 32'h0, 16'h0, 1'b1, 1'b1, tl, es);
    idle(8);
    exp = model(f, 14, es);
    checks++; if (obs_cs.size() !== 1) begin failures++; $display("FAIL tail_count: got %0d expected 1", obs_cs.size()); end
    else begin
      checks++; if (obs_cs[0] !== exp[15:0]) begin failures++; $display("FAIL tail_csum: got %h expected %h", obs_cs[0], exp[15:0]); end
    end
  endtask

  task automatic test_back_to_back();
    bq_t f [3];
    int tl [3];
    logic [31:0] es [3];
    logic [16:0] exp;
    clear_obs();
    f[0] = rnd_frame(30);
    f[1] = rnd_frame(22);
    send(f[0], 4, 32'h0, 16'h0, 1'b1, 1'b0, tl[0], es[0]);
    send(f[1], 4, 32'h0, 16'h0, 1'b0, 1'b0, tl[1], es[1]);
    idle(10);
    exp = model(f[0], 4, es[0]);
    checks++; if (obs_cs.size() !== 1) begin failures++; $display("FAIL b2b_en_count: got %0d expected 1", obs_cs.size()); end
    else begin
      checks++; if (obs_cs[0] !== exp[15:0]) begin failures++; $display("FAIL b2b_en_csum: got %h expected %h", obs_cs[0], exp[15:0]); end
    end
    clear_obs();
    for (int i = 0; i < 3; i++) f[i] = rnd_frame($urandom_range(1, KW));
    for (int i = 0; i < 3; i++) send(f[i], 0, $urandom, 16'($urandom), 1'b1, 1'b0, tl[i], es[i]);
    idle(10);
    checks++; if (obs_cs.size() !== 3) begin failures++; $display("FAIL b2b_single_count: got %0d expected 3", obs_cs.size()); end
    else for (int i = 0; i < 3; i++) begin
      exp = model(f[i], 0, es[i]);
      checks++; if (obs_cs[i] !== exp[15:0]) begin failures++; $display("FAIL b2b_single%0d_csum: got %h expected %h", i, obs_cs[i], exp[15:0]); end
      checks++; if (obs_ok[i] !== exp[16]) begin failures++; $display("FAIL b2b_single%0d_ok: got %b expected %b", i, obs_ok[i], exp[16]); end
      checks++; if (obs_cyc[i] !== tl[i] + 3) begin failures++; $display("FAIL b2b_single%0d_latency: got %0d expected %0d", i, obs_cyc[i], tl[i] + 3); end
    end
  endtask

  task automatic test_start_err();
    bq_t f;
    int tl;
    logic [31:0] es;
    logic [15:0] prev;
    logic [16:0] exp;
    @(negedge clk);
    prev = o_csum;
    clear_obs();
    f = mk_ip();
    send(f, 15, 32'h0, 16'h0, 1'b1, 1'b0, tl, es);
    idle(8);
    checks++; if (obs_cs.size() !== 0) begin failures++; $display("FAIL oddstart_valid: got %0d pulses expected 0", obs_cs.size()); end
    checks++; if (err_cyc.size() !== 1) begin failures++; $display("FAIL oddstart_err_count: got %0d expected 1", err_cyc.size()); end
    else begin
      checks++; if (err_cyc[0] !== tl + 3) begin failures++; $display("FAIL oddstart_err_slot: got %0d expected %0d", err_cyc[0], tl + 3); end
    end
    checks++; if (o_csum !== prev) begin failures++; $display("FAIL oddstart_hold: got %h expected %h", o_csum, prev); end
    clear_obs();
    send(rnd_frame(40), 2, 32'h0, 16'h0, 1'b0, 1'b1, tl, es);
    idle(8);
    checks++; if (obs_cs.size() !== 0) begin failures++; $display("FAIL disabled_valid: got %0d pulses expected 0", obs_cs.size()); end
    checks++; if (o_csum !== prev) begin failures++; $display("FAIL disabled_hold: got %h expected %h", o_csum, prev); end
    clear_obs();
    f = rnd_frame(20);
    send(f, 40, 32'h0000_1234, 16'h2, 1'b1, 1'b0, tl, es);
    idle(8);
    exp = model(f, 40, es);
    checks++; if (obs_cs.size() !== 1) begin failures++; $display("FAIL beyond_count: got %0d expected 1", obs_cs.size()); end
    else begin
      checks++; if (obs_cs[0] !== exp[15:0]) begin failures++; $display("FAIL beyond_csum: got %h expected %h", obs_cs[0], exp[15:0]); end
    end
  endtask

  task automatic test_reset_midframe();
    bq_t f;
    int tl;
    logic [31:0] es;
    logic [16:0] exp;
    clear_obs();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tvalid = 1'b1; tkeep = '1; tlast = 1'b0; tdata = {$urandom, $urandom};
      cstart = '0; seed_v = 1'b1; seed = $urandom; fen = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b1; tlast = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; tvalid = 1'b0;
    f = rnd_frame(27);
    send(f, 6, 32'h0, 16'h0, 1'b1, 1'b0, tl, es);
    idle(8);
    exp = model(f, 6, es);
    checks++; if (obs_cs.size() !== 1) begin failures++; $display("FAIL midreset_count: got %0d expected 1", obs_cs.size()); end
    else begin
      checks++; if (obs_cs[0] !== exp[15:0]) begin failures++; $display("FAIL midreset_csum: got %h expected %h", obs_cs[0], exp[15:0]); end
      checks++; if (obs_ok[0] !== exp[16]) begin failures++; $display("FAIL midreset_ok: got %b expected %b", obs_ok[0], exp[16]); end
    end
    clear_obs();
    send(rnd_frame(16), 0, 32'h0, 16'h0, 1'b1, 1'b0, tl, es);
    @(posedge clk); #1;
    rst = 1'b1; tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(8);
    checks++; if (obs_cs.size() !== 0) begin failures++; $display("FAIL inflight_reset_count: got %0d expected 0", obs_cs.size()); end
    checks++; if (o_csum !== 16'h0) begin failures++; $display("FAIL inflight_reset_csum: got %h expected 0000", o_csum); end
  endtask

  task automatic test_random();
    bq_t f;
    int tl, len, start;
    logic en;
    logic [31:0] es;
    logic [16:0] exp;
    for (int t = 0; t < 40; t++) begin
      clear_obs();
      len = $urandom_range(1, 80);
      start = $urandom_range(0, len + 6) & ~1;
      en = $urandom_range(0, 4) != 0;
      f = rnd_frame(len);
      send(f, start, $urandom, 16'($urandom), en, 1'($urandom), tl, es);
      idle(7);
      exp = model(f, start, es);
      checks++; if (obs_cs.size() !== (en ? 1 : 0)) begin failures++; $display("FAIL rand%0d_count: got %0d expected %0d", t, obs_cs.size(), en ? 1 : 0); end
      else if (en) begin
        checks++; if (obs_cs[0] !== exp[15:0]) begin failures++; $display("FAIL rand%0d_csum: got %h expected %h", t, obs_cs[0], exp[15:0]); end
        checks++; if (obs_ok[0] !== exp[16]) begin failures++; $display("FAIL rand%0d_ok: got %b expected %b", t, obs_ok[0], exp[16]); end
        checks++; if (obs_cyc[0] !== tl + 3) begin failures++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, obs_cyc[0], tl + 3); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_start_err();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
